// File: rtl/multi_proximity_scanner_pkg.sv
// Shared types and default timing for the multi-channel ultrasonic ranging controller.
// Timing defaults assume a 50 MHz system clock.
package prox_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_WAIT_RISE,
    ST_MEASURE,
    ST_GAP
  } state_e;

  localparam int DEF_N_CH           = 4;
  localparam int DEF_CNT_W          = 22;
  localparam int DEF_TRIG_CYCLES    = 500;
  localparam int DEF_TIMEOUT_CYCLES = 1_500_000;
  localparam int DEF_GAP_CYCLES     = 50_000;
  localparam int DEF_HYST           = 1_000;

endpackage

// File: rtl/multi_proximity_scanner_if.sv
// Scan request, sensor lines and per-channel results of the proximity scanner.
interface multi_proximity_scanner_if
  import prox_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int CNT_W = DEF_CNT_W
);
  logic                    measure;
  logic [N_CH-1:0]         ch_en;
  logic [CNT_W-1:0]        near_thresh;
  logic [N_CH-1:0]         echo;
  logic [N_CH-1:0]         trig;
  logic                    busy;
  logic                    done;
  logic [N_CH*CNT_W-1:0]   dist_raw;
  logic [N_CH-1:0]         valid;
  logic [N_CH-1:0]         timeout;
  logic [N_CH-1:0]         near;

  modport master (
    output measure, ch_en, near_thresh, echo,
    input  trig, busy, done, dist_raw, valid, timeout, near
  );

  modport slave (
    input  measure, ch_en, near_thresh, echo,
    output trig, busy, done, dist_raw, valid, timeout, near
  );
endinterface

// File: rtl/multi_proximity_scanner_echo_sync_edge.sv
// Two-flop synchroniser for one raw echo line plus single-cycle rise/fall pulses.
// Both edges see the same latency, so pulse spacing equals the raw high width.
module echo_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic echo_i,
  output logic rise_o,
  output logic fall_o
);
  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[1:0], echo_i};
  end

  assign rise_o = sync_q[1] & ~sync_q[2];
  assign fall_o = ~sync_q[1] & sync_q[2];
endmodule

// File: rtl/multi_proximity_scanner.sv
// Sequential trigger/echo scanner: one shared timer and FSM, channel index muxes the sensor.
// States: IDLE wait scan | TRIG pulse trigger | WAIT_RISE await echo | MEASURE count width | GAP dead time
module multi_proximity_scanner
  import prox_pkg::*;
#(
  parameter int N_CH           = DEF_N_CH,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int HYST           = DEF_HYST
) (
  input logic                       clk,
  input logic                       rst_n,
  multi_proximity_scanner_if.slave  bus_if
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_FULL   = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          tmr_q, tmr_d;
  logic [CH_W-1:0]           ch_q, ch_d, first_idx, next_idx;
  logic                      first_vld, next_vld;
  logic                      done_q, done_d;
  logic                      rec_ok, rec_to;
  logic [N_CH-1:0]           echo_rise, echo_fall, trig;
  logic [N_CH-1:0][CNT_W-1:0] dist_q;
  logic [N_CH-1:0]           valid_q, timeout_q, near_q;
  logic [CNT_W:0]            release_lvl;

  for (genvar g = 0; g < N_CH; g++) begin : g_sync
    echo_sync_edge u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .echo_i (bus_if.echo[g]),
      .rise_o (echo_rise[g]),
      .fall_o (echo_fall[g])
    );
  end

  // Descending scan so the lowest qualifying index wins.
  always_comb begin
    first_vld = 1'b0;
    first_idx = '0;
    next_vld  = 1'b0;
    next_idx  = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (bus_if.ch_en[i]) begin
        first_vld = 1'b1;
        first_idx = CH_W'(i);
        if (i > int'(ch_q)) begin
          next_vld = 1'b1;
          next_idx = CH_W'(i);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      ch_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      ch_q    <= ch_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    ch_d    = ch_q;
    done_d  = 1'b0;
    rec_ok  = 1'b0;
    rec_to  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus_if.measure) begin
          if (first_vld) begin
            state_d = ST_TRIG;
            ch_d    = first_idx;
            tmr_d   = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_TRIG: begin
        if (tmr_q == TRIG_LAST) begin
          state_d = ST_WAIT_RISE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_WAIT_RISE: begin
        // The rise cycle is itself the first high cycle of the echo.
        if (echo_rise[ch_q]) begin
          state_d = ST_MEASURE;
          tmr_d   = CNT_W'(1);
        end else if (tmr_q == TO_LAST) begin
          rec_to  = 1'b1;
          state_d = ST_GAP;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_MEASURE: begin
        if (echo_fall[ch_q]) begin
          rec_ok  = 1'b1;
          state_d = ST_GAP;
          tmr_d   = '0;
        end else if (tmr_q == TO_FULL) begin
          rec_to  = 1'b1;
          state_d = ST_GAP;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (tmr_q == GAP_LAST) begin
          tmr_d = '0;
          if (next_vld) begin
            state_d = ST_TRIG;
            ch_d    = next_idx;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign release_lvl = {1'b0, bus_if.near_thresh} + (CNT_W + 1)'(HYST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dist_q    <= '0;
      valid_q   <= '0;
      timeout_q <= '0;
      near_q    <= '0;
    end else if (rec_ok) begin
      dist_q[ch_q]    <= tmr_q;
      valid_q[ch_q]   <= 1'b1;
      timeout_q[ch_q] <= 1'b0;
      if (tmr_q < bus_if.near_thresh)       near_q[ch_q] <= 1'b1;
      else if ({1'b0, tmr_q} >= release_lvl) near_q[ch_q] <= 1'b0;
    end else if (rec_to) begin
      dist_q[ch_q]    <= TO_FULL;
      valid_q[ch_q]   <= 1'b0;
      timeout_q[ch_q] <= 1'b1;
      near_q[ch_q]    <= 1'b0;
    end
  end

  always_comb begin
    trig = '0;
    if (state_q == ST_TRIG) trig[ch_q] = 1'b1;
  end

  assign bus_if.trig     = trig;
  assign bus_if.busy     = (state_q != ST_IDLE);
  assign bus_if.done     = done_q;
  assign bus_if.dist_raw = dist_q;
  assign bus_if.valid    = valid_q;
  assign bus_if.timeout  = timeout_q;
  assign bus_if.near     = near_q;
endmodule

// File: tb/tb_multi_proximity_scanner.sv
// Bench for the proximity scanner: sensor responders, a trig/done monitor and a
// per-channel result model built from the ranging rules.
module tb_multi_proximity_scanner;
  localparam int N     = 4;
  localparam int CW    = 16;
  localparam int TRIGC = 20;
  localparam int TOC   = 2000;
  localparam int GAPC  = 50;
  localparam int HYS   = 100;
  localparam int BUD   = 20000;

  logic clk, rst_n;
  multi_proximity_scanner_if #(.N_CH(N), .CNT_W(CW)) bus();

  multi_proximity_scanner #(
    .N_CH(N), .CNT_W(CW), .TRIG_CYCLES(TRIGC), .TIMEOUT_CYCLES(TOC),
    .GAP_CYCLES(GAPC), .HYST(HYS)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // sensor behaviour: 0 normal echo, 1 silent, 2 stuck high
  int mode [N];
  int dly_cfg [N];
  int wid_cfg [N];
  int thr;

  int m_dist [N];
  bit m_valid [N];
  bit m_to [N];
  bit m_near [N];

  int seq[$], sep_q[$], tr_w[$];
  int done_cnt = 0, onehot_err = 0, done_busy_err = 0;
  int b_seq, b_tw, b_done, b_oh, b_db;

  initial begin : responder
    int dly_cnt [N];
    int hi_cnt [N];
    logic [N-1:0] prev_trig;
    prev_trig = '0;
    bus.echo = '0;
    for (int c = 0; c < N; c++) begin dly_cnt[c] = 0; hi_cnt[c] = 0; end
    forever begin
      @(negedge clk);
      for (int c = 0; c < N; c++) begin
        if (!rst_n) begin
          dly_cnt[c] = 0;
          hi_cnt[c]  = 0;
        end else if (prev_trig[c] && !bus.trig[c] && mode[c] == 0) begin
          dly_cnt[c] = dly_cfg[c];
          hi_cnt[c]  = wid_cfg[c];
        end
        if (mode[c] == 2) bus.echo[c] = 1'b1;
        else if (dly_cnt[c] > 0) begin dly_cnt[c]--; bus.echo[c] = 1'b0; end
        else if (hi_cnt[c] > 0) begin hi_cnt[c]--; bus.echo[c] = 1'b1; end
        else bus.echo[c] = 1'b0;
      end
      prev_trig = bus.trig;
    end
  end

  initial begin : monitor
    int tr_len [N];
    int cyc, last_fall;
    cyc = 0;
    last_fall = 0;
    for (int c = 0; c < N; c++) tr_len[c] = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        for (int c = 0; c < N; c++) tr_len[c] = 0;
      end else begin
        for (int c = 0; c < N; c++) begin
          if (bus.trig[c]) begin
            if (tr_len[c] == 0) begin seq.push_back(c); sep_q.push_back(cyc - last_fall); end
            tr_len[c]++;
          end else if (tr_len[c] != 0) begin
            tr_w.push_back(tr_len[c]);
            tr_len[c] = 0;
            last_fall = cyc;
          end
        end
        if ($countones(bus.trig) > 1) onehot_err++;
        if (bus.done) begin
          done_cnt++;
          if (bus.busy) done_busy_err++;
        end
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // Expected effect of one scan over the enabled channels.
  task automatic model_scan(input logic [N-1:0] mask);
    for (int c = 0; c < N; c++) begin
      if (mask[c]) begin
        if (mode[c] == 0 && wid_cfg[c] < TOC) begin
          m_dist[c] = wid_cfg[c];
          m_valid[c] = 1'b1;
          m_to[c] = 1'b0;
          if (wid_cfg[c] < thr) m_near[c] = 1'b1;
          else if (wid_cfg[c] >= thr + HYS) m_near[c] = 1'b0;
        end else begin
          m_dist[c] = TOC;
          m_valid[c] = 1'b0;
          m_to[c] = 1'b1;
          m_near[c] = 1'b0;
        end
      end
    end
  endtask

  task automatic start_scan(input logic [N-1:0] mask);
    bus.ch_en = mask;
    bus.near_thresh = CW'(thr);
    b_seq = seq.size(); b_tw = tr_w.size(); b_done = done_cnt;
    b_oh = onehot_err; b_db = done_busy_err;
    @(negedge clk) bus.measure = 1'b1;
    @(negedge clk) bus.measure = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cnt == b_done && n < BUD) begin @(negedge clk); n++; end
    checks++;
    if (done_cnt == b_done) begin
      errors++;
      $display("FAIL %s done_wait: no done pulse within %0d cycles, required one", tag, BUD);
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.measure = 1'b0;
    bus.ch_en = '0;
    bus.near_thresh = '0;
    thr = 0;
    for (int c = 0; c < N; c++) begin
      mode[c] = 0; dly_cfg[c] = 10; wid_cfg[c] = 100;
      m_dist[c] = 0; m_valid[c] = 0; m_to[c] = 0; m_near[c] = 0;
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.trig, bus.busy, bus.done, bus.dist_raw, bus.valid, bus.timeout, bus.near} !== '0) begin
      errors++;
      $display("FAIL reset_hold: outputs %h required 0", {bus.trig, bus.busy, bus.done, bus.dist_raw});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.trig, bus.busy, bus.done, bus.dist_raw, bus.valid, bus.timeout, bus.near} !== '0) begin
      errors++;
      $display("FAIL reset_release: outputs %h required 0", {bus.trig, bus.busy, bus.done, bus.dist_raw});
    end
  endtask

  task automatic test_single;
    thr = 500;
    dly_cfg[0] = 100;
    wid_cfg[0] = $urandom_range(800, 1500);
    start_scan(4'b0001);
    checks++;
    if ({bus.busy, bus.trig} !== {1'b1, 4'b0001}) begin
      errors++;
      $display("FAIL single_start: busy/trig %b required 1_0001", {bus.busy, bus.trig});
    end
    model_scan(4'b0001);
    wait_done("single");
    checks++;
    if (done_cnt - b_done != 1 || done_busy_err != b_db || onehot_err != b_oh) begin
      errors++;
      $display("FAIL single_done: pulses %0d busy_at_done %0d required 1 and 0", done_cnt - b_done, done_busy_err - b_db);
    end
    checks++;
    if (tr_w.size() - b_tw != 1 || tr_w[tr_w.size()-1] != TRIGC) begin
      errors++;
      $display("FAIL single_trig_width: got %0d pulses last %0d required 1 of %0d", tr_w.size() - b_tw, tr_w[tr_w.size()-1], TRIGC);
    end
    for (int c = 0; c < N; c++) begin
      checks++;
      if ({bus.dist_raw[c*CW +: CW], bus.valid[c], bus.timeout[c], bus.near[c]} !== {CW'(m_dist[c]), m_valid[c], m_to[c], m_near[c]}) begin
        errors++;
        $display("FAIL single_ch%0d: dist/v/t/n %0d/%b/%b/%b required %0d/%b/%b/%b", c, bus.dist_raw[c*CW +: CW], bus.valid[c], bus.timeout[c], bus.near[c], m_dist[c], m_valid[c], m_to[c], m_near[c]);
      end
    end
  endtask

  task automatic test_skip;
    thr = 1000;
    for (int c = 0; c < N; c++) begin
      dly_cfg[c] = $urandom_range(1, 200);
      wid_cfg[c] = $urandom_range(300, 1200);
    end
    start_scan(4'b1010);
    model_scan(4'b1010);
    wait_done("skip");
    checks++;
    if (seq.size() - b_seq != 2 || seq[b_seq] != 1 || seq[b_seq+1] != 3) begin
      errors++;
      $display("FAIL skip_order: %0d triggers, first ch %0d, required channels 1 then 3", seq.size() - b_seq, seq[b_seq]);
    end
    checks++;
    if (sep_q[b_seq+1] < GAPC) begin
      errors++;
      $display("FAIL skip_gap: %0d idle cycles between triggers, required >= %0d", sep_q[b_seq+1], GAPC);
    end
    for (int k = b_tw; k < tr_w.size(); k++) begin
      checks++;
      if (tr_w[k] != TRIGC) begin
        errors++;
        $display("FAIL skip_trig_width: got %0d required %0d", tr_w[k], TRIGC);
      end
    end
    for (int c = 0; c < N; c++) begin
      checks++;
      if ({bus.dist_raw[c*CW +: CW], bus.valid[c], bus.timeout[c], bus.near[c]} !== {CW'(m_dist[c]), m_valid[c], m_to[c], m_near[c]}) begin
        errors++;
        $display("FAIL skip_ch%0d: dist/v/t/n %0d/%b/%b/%b required %0d/%b/%b/%b", c, bus.dist_raw[c*CW +: CW], bus.valid[c], bus.timeout[c], bus.near[c], m_dist[c], m_valid[c], m_to[c], m_near[c]);
      end
    end
  endtask

  task automatic test_timeout;
    // silent sensor, valid echo, over-long echo, echo stuck high before trigger
    int wids [4] = '{100, 700, TOC + 50, 100};
    int modes [4] = '{1, 0, 0, 2};
    int exp_d [4] = '{TOC, 700, TOC, TOC};
    bit exp_v [4] = '{0, 1, 0, 0};
    thr = 500;
    dly_cfg[2] = 30;
    for (int k = 0; k < 4; k++) begin
      mode[2] = modes[k];
      wid_cfg[2] = wids[k];
      repeat (4) @(negedge clk);
      start_scan(4'b0100);
      model_scan(4'b0100);
      wait_done("timeout");
      checks++;
      if ({bus.dist_raw[2*CW +: CW], bus.valid[2], bus.timeout[2]} !== {CW'(exp_d[k]), exp_v[k], ~exp_v[k]}) begin
        errors++;
        $display("FAIL timeout_case%0d: dist/v/t %0d/%b/%b required %0d/%b/%b", k, bus.dist_raw[2*CW +: CW], bus.valid[2], bus.timeout[2], exp_d[k], exp_v[k], ~exp_v[k]);
      end
      checks++;
      if ({bus.dist_raw, bus.valid, bus.timeout, bus.near} !== {CW'(m_dist[3]), CW'(m_dist[2]), CW'(m_dist[1]), CW'(m_dist[0]),
           m_valid[3], m_valid[2], m_valid[1], m_valid[0], m_to[3], m_to[2], m_to[1], m_to[0], m_near[3], m_near[2], m_near[1], m_near[0]}) begin
        errors++;
        $display("FAIL timeout_model%0d: dist_raw %h valid %b timeout %b near %b", k, bus.dist_raw, bus.valid, bus.timeout, bus.near);
      end
    end
    mode[2] = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_near;
    int wids [3] = '{9000 / 10, 10500 / 10, 11000 / 10};
    bit exp_n [3] = '{1, 1, 0};
    thr = 1000;
    dly_cfg[0] = 20;
    for (int k = 0; k < 3; k++) begin
      wid_cfg[0] = wids[k];
      start_scan(4'b0001);
      model_scan(4'b0001);
      wait_done("near");
      checks++;
      if ({bus.near[0], bus.dist_raw[CW-1:0]} !== {exp_n[k], CW'(wids[k])}) begin
        errors++;
        $display("FAIL near_step%0d: near %b dist %0d required %b %0d", k, bus.near[0], bus.dist_raw[CW-1:0], exp_n[k], wids[k]);
      end
    end
  endtask

  task automatic test_busy_ignore;
    dly_cfg[0] = 15;
    wid_cfg[0] = 600;
    start_scan(4'b0001);
    repeat (100) @(negedge clk);
    bus.measure = 1'b1;
    @(negedge clk) bus.measure = 1'b0;
    model_scan(4'b0001);
    wait_done("busy_ignore");
    checks++;
    if (done_cnt - b_done != 1 || seq.size() - b_seq != 1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignore: done pulses %0d triggers %0d busy %b required 1 1 0", done_cnt - b_done, seq.size() - b_seq, bus.busy);
    end
  endtask

  task automatic test_reset_mid;
    dly_cfg[0] = 10;
    wid_cfg[0] = 1500;
    start_scan(4'b0001);
    repeat (TRIGC + 400) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre: busy %b required 1 before reset", bus.busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.trig, bus.busy, bus.done, bus.dist_raw, bus.valid, bus.timeout, bus.near} !== '0) begin
      errors++;
      $display("FAIL reset_mid_async: outputs %h required 0", {bus.trig, bus.busy, bus.done, bus.dist_raw, bus.valid, bus.timeout, bus.near});
    end
    for (int c = 0; c < N; c++) begin m_dist[c] = 0; m_valid[c] = 0; m_to[c] = 0; m_near[c] = 0; end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    wid_cfg[0] = 400;
    start_scan(4'b0001);
    model_scan(4'b0001);
    wait_done("reset_mid");
    for (int c = 0; c < N; c++) begin
      checks++;
      if ({bus.dist_raw[c*CW +: CW], bus.valid[c], bus.timeout[c], bus.near[c]} !== {CW'(m_dist[c]), m_valid[c], m_to[c], m_near[c]}) begin
        errors++;
        $display("FAIL reset_mid_ch%0d: dist/v/t/n %0d/%b/%b/%b required %0d/%b/%b/%b", c, bus.dist_raw[c*CW +: CW], bus.valid[c], bus.timeout[c], bus.near[c], m_dist[c], m_valid[c], m_to[c], m_near[c]);
      end
    end
  endtask

  task automatic test_empty;
    start_scan(4'b0000);
    checks++;
    if ({bus.done, bus.busy, bus.trig} !== {1'b1, 1'b0, 4'b0000}) begin
      errors++;
      $display("FAIL empty_t1: done/busy/trig %b required 1_0_0000", {bus.done, bus.busy, bus.trig});
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL empty_pulse: done %b one cycle later, required 0", bus.done);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (done_cnt - b_done != 1 || seq.size() != b_seq || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL empty_quiet: done pulses %0d triggers %0d busy %b required 1 0 0", done_cnt - b_done, seq.size() - b_seq, bus.busy);
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 5; it++) begin
      logic [N-1:0] mask;
      int exp_seq[$];
      bit ok;
      mask = N'($urandom_range(1, 15));
      thr = $urandom_range(200, 1200);
      for (int c = 0; c < N; c++) begin
        mode[c] = ($urandom_range(0, 7) == 0) ? 1 : 0;
        dly_cfg[c] = $urandom_range(1, 300);
        wid_cfg[c] = $urandom_range(50, 1200);
        if (mask[c]) exp_seq.push_back(c);
      end
      start_scan(mask);
      model_scan(mask);
      wait_done("random");
      ok = (seq.size() - b_seq == exp_seq.size());
      for (int k = 0; ok && k < exp_seq.size(); k++) if (seq[b_seq+k] != exp_seq[k]) ok = 0;
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL random%0d_order: %0d triggers for mask %b, required %0d in ascending order", it, seq.size() - b_seq, mask, exp_seq.size());
      end
      for (int c = 0; c < N; c++) begin
        checks++;
        if ({bus.dist_raw[c*CW +: CW], bus.valid[c], bus.timeout[c], bus.near[c]} !== {CW'(m_dist[c]), m_valid[c], m_to[c], m_near[c]}) begin
          errors++;
          $display("FAIL random%0d_ch%0d: dist/v/t/n %0d/%b/%b/%b required %0d/%b/%b/%b", it, c, bus.dist_raw[c*CW +: CW], bus.valid[c], bus.timeout[c], bus.near[c], m_dist[c], m_valid[c], m_to[c], m_near[c]);
        end
      end
      checks++;
      if (onehot_err != b_oh || done_busy_err != b_db) begin
        errors++;
        $display("FAIL random%0d_protocol: multi-hot cycles %0d done-while-busy %0d required 0 0", it, onehot_err - b_oh, done_busy_err - b_db);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_skip();
    test_timeout();
    test_near();
    test_busy_ignore();
    test_reset_mid();
    test_empty();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
